// File: rtl/vec_sum_seq_pkg.sv
// Shared definitions for the vector-sum reduction controller: FSM encoding,
// the positive-zero constant and the default element-counter width.
package vec_sum_seq_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    GET_FIRST = 3'd0,
    GET       = 3'd1,
    SEND      = 3'd2,
    WAIT      = 3'd3,
    PUT       = 3'd4
  } state_t;

endpackage

// File: rtl/vec_sum_seq_if.sv
// Handshake bundle of vec_sum_seq: element input, adder operand/result ports
// and the sum output. slave is the controller's view, master the environment's.
interface vec_sum_seq_if
  import vec_sum_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic [31:0]      in_data;
    logic             in_last;
    logic             in_stb;
    logic             in_ack;

    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic             add_stb;
    logic             add_ack;
    logic [31:0]      add_z;
    logic             add_z_stb;
    logic             add_z_ack;

    logic [31:0]      sum_z;
    logic [CNT_W-1:0] sum_count;
    logic             sum_stb;
    logic             sum_ack;

    modport slave (
        input  in_data, in_last, in_stb,
        output in_ack,
        output add_a, add_b, add_stb,
        input  add_ack,
        input  add_z, add_z_stb,
        output add_z_ack,
        output sum_z, sum_count, sum_stb,
        input  sum_ack
    );

    modport master (
        output in_data, in_last, in_stb,
        input  in_ack,
        input  add_a, add_b, add_stb,
        output add_ack,
        output add_z, add_z_stb,
        input  add_z_ack,
        input  sum_z, sum_count, sum_stb,
        output sum_ack
    );

endinterface

// File: rtl/vec_sum_seq.sv
// Sequential FP vector reduction: streams elements through an external adder,
// keeping the running sum locally and reporting sum plus saturating count.
module vec_sum_seq
  import vec_sum_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    vec_sum_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [31:0]      acc;
    logic [31:0]      elem;
    logic             last_r;
    logic [CNT_W-1:0] count;

    // NOTE: every register here is assigned with <= so all updates in a cycle
    // see the pre-edge values, matching the registered handshake semantics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= GET_FIRST;
            acc           <= FP_POS_ZERO;
            elem          <= FP_POS_ZERO;
            last_r        <= 1'b0;
            count         <= '0;
            bus.in_ack    <= 1'b0;
            bus.add_a     <= FP_POS_ZERO;
            bus.add_b     <= FP_POS_ZERO;
            bus.add_stb   <= 1'b0;
            bus.add_z_ack <= 1'b0;
            bus.sum_z     <= FP_POS_ZERO;
            bus.sum_count <= '0;
            bus.sum_stb   <= 1'b0;
        end else begin
            case (state)
                GET_FIRST: begin
                    bus.in_ack <= 1'b1;
                    if (bus.in_stb && bus.in_ack) begin
                        // First element bypasses the adder, preserving it bit-exactly.
                        acc        <= bus.in_data;
                        count      <= CNT_ONE;
                        bus.in_ack <= 1'b0;
                        state      <= bus.in_last ? PUT : GET;
                    end
                end

                GET: begin
                    bus.in_ack <= 1'b1;
                    if (bus.in_stb && bus.in_ack) begin
                        elem       <= bus.in_data;
                        last_r     <= bus.in_last;
                        count      <= (count == CNT_MAX) ? count : count + CNT_ONE;
                        bus.in_ack <= 1'b0;
                        state      <= SEND;
                    end
                end

                SEND: begin
                    // acc and elem cannot change in SEND, so the operands stay stable.
                    bus.add_a   <= acc;
                    bus.add_b   <= elem;
                    bus.add_stb <= 1'b1;
                    if (bus.add_stb && bus.add_ack) begin
                        bus.add_stb <= 1'b0;
                        state       <= WAIT;
                    end
                end

                WAIT: begin
                    bus.add_z_ack <= 1'b1;
                    if (bus.add_z_stb && bus.add_z_ack) begin
                        acc           <= bus.add_z;
                        bus.add_z_ack <= 1'b0;
                        state         <= last_r ? PUT : GET;
                    end
                end

                PUT: begin
                    bus.sum_z     <= acc;
                    bus.sum_count <= count;
                    bus.sum_stb   <= 1'b1;
                    if (bus.sum_stb && bus.sum_ack) begin
                        bus.sum_stb <= 1'b0;
                        acc         <= FP_POS_ZERO;
                        count       <= '0;
                        state       <= GET_FIRST;
                    end
                end

                default: state <= GET_FIRST;
            endcase
        end
    end

endmodule
